// File: rtl/inv_k2j.sv
// inv_k2j: fixed-point inverse kinematics for a planar two-link arm (l1 = l2 = 0.5), one result per 40 cycles
// Ports: in0/in1 target x/y (signed Q16.16, sampled only in CAPTURE)
//        out0/out1 theta1/theta2 (signed Q16.16 radians, registered, updated in DONE)
//        clk rising-edge clock, rst synchronous active-low reset
module inv_k2j (
  input  logic signed [31:0] in0,
  input  logic signed [31:0] in1,
  output logic signed [31:0] out0,
  output logic signed [31:0] out1,
  input  logic               clk,
  input  logic               rst
);
  typedef enum logic [2:0] {s_capture, s_prep, s_sqrt, s_cordic, s_done} state_t;
  localparam logic signed [33:0] pi   = 34'sd205887;
  localparam logic signed [33:0] pi_2 = 34'sd102944;
  localparam logic signed [33:0] one  = 34'sd65536;
  localparam logic [15:0] atan_tab [16] = '{
    16'd51472, 16'd30386, 16'd16055, 16'd8150, 16'd4091, 16'd2047, 16'd1024, 16'd512,
    16'd256,   16'd128,   16'd64,    16'd32,   16'd16,   16'd8,    16'd4,    16'd2
  };
  state_t             r_state, w_state_nx;
  logic [4:0]         r_cnt, w_cnt_nx;
  logic               w_last;
  logic signed [31:0] r_x, r_y;
  logic [31:0]        r_r2;
  logic signed [17:0] r_c2;
  logic [33:0]        r_rad;
  logic [18:0]        r_rem;
  logic [16:0]        r_q;
  logic signed [33:0] r_ax, r_ay, r_az, r_bx, r_by, r_bz, r_a, r_b;
  logic signed [63:0] w_xx, w_yy;
  logic [47:0]        w_r2;
  logic signed [33:0] w_c2;
  logic signed [35:0] w_c2sq;
  logic [16:0]        w_rad;
  logic [20:0]        w_rs, w_tr;
  logic               w_ge, w_small;
  logic signed [33:0] w_xe, w_ye, w_at;
  logic [3:0]         w_sh;
  always_comb begin
    w_xx = 64'(r_x) * 64'(r_x);
    w_yy = 64'(r_y) * 64'(r_y);
    w_r2 = 48'(({1'b0, w_xx} + {1'b0, w_yy}) >> 16);
    w_c2 = $signed({1'b0, r_r2, 1'b0}) - one;
    w_c2sq = 36'(r_c2) * 36'(r_c2);
    w_rad = 17'(36'sd65536 - (w_c2sq >>> 16));
    w_rs = {r_rem, r_rad[33:32]};
    w_tr = {2'b00, r_q, 2'b01};
    w_ge = w_rs >= w_tr;
    // small targets get 9 guard bits so CORDIC truncation stays well inside the error budget
    w_small = (&r_x[31:22] | ~|r_x[31:22]) & (&r_y[31:22] | ~|r_y[31:22]);
    w_xe = w_small ? 34'(r_x) <<< 9 : 34'(r_x);
    w_ye = w_small ? 34'(r_y) <<< 9 : 34'(r_y);
    w_sh = 4'(r_cnt - 5'd1);
    w_at = {18'd0, atan_tab[w_sh]};
    w_last = (r_state == s_capture) | (r_state == s_done) | (r_state == s_prep && r_cnt == 5'd2) |
             (r_state == s_sqrt && r_cnt == 5'd16) | (r_state == s_cordic && r_cnt == 5'd17);
    w_state_nx = !w_last ? r_state :
                 r_state == s_capture ? s_prep :
                 r_state == s_prep ? s_sqrt :
                 r_state == s_sqrt ? s_cordic :
                 r_state == s_cordic ? s_done : s_capture;
    w_cnt_nx = w_last ? 5'd0 : r_cnt + 5'd1;
  end
  always_ff @(posedge clk) begin
    r_state <= !rst ? s_capture : w_state_nx;
    r_cnt <= !rst ? 5'd0 : w_cnt_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out0 <= '0;
      out1 <= '0;
      r_x <= '0;
      r_y <= '0;
      r_r2 <= '0;
      r_c2 <= '0;
      r_rad <= '0;
      r_rem <= '0;
      r_q <= '0;
      r_ax <= '0;
      r_ay <= '0;
      r_az <= '0;
      r_bx <= '0;
      r_by <= '0;
      r_bz <= '0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      case (r_state)
        s_capture: begin
          r_x <= in0;
          r_y <= in1;
        end
        s_prep: begin
          if (r_cnt == 5'd0) r_r2 <= |w_r2[47:32] ? '1 : w_r2[31:0];
          if (r_cnt == 5'd1) r_c2 <= (w_c2 > one) ? 18'sd65536 : w_c2[17:0];
          if (r_cnt == 5'd2) begin
            r_rad <= {1'b0, w_rad, 16'd0};
            r_rem <= '0;
            r_q <= '0;
          end
        end
        s_sqrt: begin
          r_rem <= 19'(w_ge ? w_rs - w_tr : w_rs);
          r_q <= {r_q[15:0], w_ge};
          r_rad <= r_rad << 2;
        end
        s_cordic: begin
          if (r_cnt == 5'd0) begin
            // left half-plane: rotate by -/+ pi/2 into the right half-plane and preload z
            r_ax <= !r_x[31] ? w_xe : r_y[31] ? -w_ye : w_ye;
            r_ay <= !r_x[31] ? w_ye : r_y[31] ? w_xe : -w_xe;
            r_az <= !r_x[31] ? '0 : r_y[31] ? -pi_2 : pi_2;
            r_bx <= (one + 34'(r_c2)) <<< 12;
            r_by <= $signed({17'd0, r_q}) <<< 12;
            r_bz <= '0;
          end else if (r_cnt == 5'd17) begin
            // y = 0 and s2 = 0 resolve exactly; also defines atan2(0,0) = 0
            r_a <= ~|r_y ? (r_x[31] ? pi : '0) : r_az;
            r_b <= ~|r_q ? '0 : r_bz;
          end else begin
            r_ax <= r_ay[33] ? r_ax - (r_ay >>> w_sh) : r_ax + (r_ay >>> w_sh);
            r_ay <= r_ay[33] ? r_ay + (r_ax >>> w_sh) : r_ay - (r_ax >>> w_sh);
            r_az <= r_ay[33] ? r_az - w_at : r_az + w_at;
            r_bx <= r_by[33] ? r_bx - (r_by >>> w_sh) : r_bx + (r_by >>> w_sh);
            r_by <= r_by[33] ? r_by + (r_bx >>> w_sh) : r_by - (r_bx >>> w_sh);
            r_bz <= r_by[33] ? r_bz - w_at : r_bz + w_at;
          end
        end
        s_done: begin
          out0 <= 32'(r_a - r_b);
          out1 <= 32'(r_b <<< 1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_k2j.sv
// tb_inv_k2j: directed-vector bench for inv_k2j with hand-computed joint angles
module tb_inv_k2j;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [31:0] in0 = '0;
  logic signed [31:0] in1 = '0;
  logic signed [31:0] out0, out1;
  logic signed [31:0] prev0 = '0;
  logic signed [31:0] prev1 = '0;
  int n_tests = 0;
  int n_fail = 0;
  inv_k2j dut (.in0(in0), .in1(in1), .out0(out0), .out1(out1), .clk(clk), .rst(rst));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want, input int tol);
    longint d;
    d = longint'(got) - longint'(want);
    if (d < 0) d = -d;
    n_tests++;
    if (d > longint'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, want, tol);
    end
  endtask
  // called #1 after an edge whose successor is a CAPTURE edge
  task automatic run(input string name, input logic signed [31:0] x, input logic signed [31:0] y,
                     input logic signed [31:0] e0, input logic signed [31:0] e1, input int tol1, input bit chg);
    in0 = x;
    in1 = y;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    if (chg) begin
      in0 = 32'sd65536;
      in1 = 32'sd0;
    end
    repeat (28) @(posedge clk);
    #1;
    check({name, ".hold0"}, out0, prev0, 16);
    check({name, ".hold1"}, out1, prev1, 16);
    @(posedge clk);
    #1;
    check({name, ".t1"}, out0, e0, 16);
    check({name, ".t2"}, out1, e1, tol1);
    prev0 = e0;
    prev1 = e1;
  endtask
  initial begin
    in0 = 32'sd123456;
    in1 = -32'sd98765;
    repeat (10) @(posedge clk);
    #1;
    check("rst.t1", out0, 32'sd0, 0);
    check("rst.t2", out1, 32'sd0, 0);
    rst = 1'b1;
    run("origin", 32'sd0, 32'sd0, 32'sd0, 32'sd0, 0, 1'b0);
    run("q45", 32'sd32768, 32'sd32768, 32'sd0, 32'sd102944, 16, 1'b0);
    run("y05", 32'sd0, 32'sd32768, 32'sd34315, 32'sd137258, 16, 1'b0);
    run("x1", 32'sd65536, 32'sd0, 32'sd0, 32'sd0, 16, 1'b0);
    run("y1", 32'sd0, 32'sd65536, 32'sd102944, 32'sd0, 16, 1'b0);
    run("xm1", -32'sd65536, 32'sd0, 32'sd205887, 32'sd0, 16, 1'b0);
    run("far", 32'sd131072, 32'sd0, 32'sd0, 32'sd0, 0, 1'b0);
    run("sat", 32'sh7FFFFFFF, 32'sd0, 32'sd0, 32'sd0, 0, 1'b0);
    run("midchg", 32'sd0, 32'sd32768, 32'sd34315, 32'sd137258, 16, 1'b1);
    in0 = 32'sd32768;
    in1 = 32'sd32768;
    @(posedge clk);
    repeat (25) @(posedge clk);
    #1;
    check("cordic.hold", out1, prev1, 16);
    rst = 1'b0;
    in0 = 32'sd0;
    in1 = 32'sd65536;
    @(posedge clk);
    #1;
    check("midrst.t1", out0, 32'sd0, 0);
    check("midrst.t2", out1, 32'sd0, 0);
    rst = 1'b1;
    prev0 = '0;
    prev1 = '0;
    run("restart", 32'sd0, 32'sd65536, 32'sd102944, 32'sd0, 16, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_k2j.md
# inv_k2j

Fixed-point inverse-kinematics core for a planar two-link arm with both link lengths 0.5. It samples a target point (x, y) and computes joint angles theta1 (shoulder) and theta2 (elbow), both in radians. The core is free-running with no handshake: it repeatedly samples its inputs and refreshes its outputs on a fixed 40-cycle period. It sits as a standalone arithmetic kernel between a sample source and a result sink.

## Interface
- No parameters. Link lengths l1 = l2 = 0.5 and all widths are fixed.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-low (sampled on the rising edge of clk while 0).
- in0  input  32  target x, signed Q16.16.
- in1  input  32  target y, signed Q16.16.
- out0  output  32  theta1, signed Q16.16 radians (registered).
- out1  output  32  theta2, signed Q16.16 radians (registered).
- Port order: in0, in1, out0, out1, clk, rst.

## Operation
- Math:
  - r2 = x² + y².
  - c2 = 2·r2 − 1, clamped to [−1, +1].
  - s2 = sqrt(1 − c2²).
  - phi = atan2(s2, 1 + c2).
  - theta2 = 2·phi.
  - theta1 = atan2(y, x) − phi.
- FSM loop: CAPTURE → PREP → SQRT → CORDIC → DONE → CAPTURE.
  - CAPTURE (1 cycle): register in0/in1 into x_r/y_r. Inputs are ignored during all other states.
  - PREP (3 cycles):
    - 64-bit squares, rescaled to Q16.16 and saturating.
    - c2, then clamp.
    - 1 − c2² (always ≥ 0).
  - SQRT (17 cycles): bit-serial restoring square root of the Q16.16 radicand, giving s2 in [0, 1] Q16.16.
  - CORDIC (18 cycles): two CORDIC vectoring units run in parallel for 16 iterations plus 2 cycles of pre-rotation and finalize.
    - Unit A computes atan2(y_r, x_r). If x < 0, pre-rotate by ±π/2 with the sign chosen from y so that the result lies in (−π, π].
    - Unit B computes atan2(s2, 1 + c2), which is always in [0, π/2].
    - Arctan table: 16 entries, Q16.16.
    - Internal datapath: 34-bit signed, to absorb the CORDIC gain.
  - DONE (1 cycle): out0 ← A − B, out1 ← B << 1. Both outputs update in the same cycle.
- Boundary rules:
  - Unreachable targets (r2 > 1) are clamped: c2 = 1, s2 = 0, theta2 = 0, theta1 = atan2(y, x).
  - Origin: atan2(0, 0) is defined as 0 for both units, so both outputs are 0.
  - x = negative, y = 0 gives theta1 = +π (205887).
  - Square overflow (|x| or |y| ≥ 256) saturates r2; the result is handled as unreachable.
- Output ranges:
  - theta1 lies in (−3π/2, π]. No wrap is applied.
  - theta2 lies in [0, π].
- Constants: π = 205887, π/2 = 102944, all in Q16.16.
- Accuracy: each output within ±16 LSB of the exact double-precision result for reachable inputs.

## Timing
- Reset (rst = 0 at a clock edge):
  - out0 = 0, out1 = 0.
  - FSM goes to CAPTURE and all internal registers clear.
  - Takes effect on that edge and overrides any state, including mid-computation. The computation in flight is discarded.
- First CAPTURE happens on the first edge with rst = 1.
- Latency: inputs sampled at CAPTURE edge n produce outputs visible after edge n + 39 (the DONE edge).
- Period: 40 cycles, then the next CAPTURE at edge n + 40.
- Outputs are held stable between DONE edges.
- Input changes between CAPTURE edges have no effect until the next CAPTURE.
- Throughput: one result per 40 cycles. Any source holding an input for at least 80 cycles is guaranteed to have it fully processed and visible.

## Test plan
- Reset: hold rst = 0 for 10 cycles with arbitrary inputs -> out0 = out1 = 0. Release with in0 = in1 = 0 -> outputs remain 0 after 40 cycles.
- in0 = 32768, in1 = 32768 (0.5, 0.5) -> out0 ≈ 0, out1 ≈ 102944 (π/2), both ±16. Result appears exactly 39 edges after capture.
- in0 = 0, in1 = 32768 -> out0 ≈ 34315 (π/6), out1 ≈ 137258 (2π/3).
- Boundaries:
  - in0 = 65536, in1 = 0 -> out0 ≈ 0, out1 ≈ 0.
  - in0 = 0, in1 = 65536 -> out0 ≈ 102944, out1 ≈ 0.
  - in0 = −65536, in1 = 0 -> out0 ≈ 205887, out1 ≈ 0.
- Unreachable and saturation:
  - in0 = 131072, in1 = 0 -> out0 ≈ 0, out1 = 0.
  - in0 = 0x7FFFFFFF, in1 = 0 -> out1 = 0, no overflow artifacts.
- Mid-operation:
  - Change inputs during SQRT -> the current result still reflects the captured values.
  - Assert rst during CORDIC -> outputs become 0 on the next edge, and the restart captures fresh inputs.
